// File: rtl/gf2_pkg.sv
// Shared types and width helpers for the GF(2)[x] arithmetic blocks.
package gf2_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIN
  } state_t;

  localparam int DEFAULT_N = 571;

  // Widths for a degree-n field: dividend/quotient, divisor, remainder, step counter.
  function automatic int dw_of(input int n);
    return 2 * n - 1;
  endfunction

  function automatic int vw_of(input int n);
    return n + 1;
  endfunction

  function automatic int rw_of(input int n);
    return n;
  endfunction

  function automatic int cw_of(input int n);
    return $clog2(2 * n - 1);
  endfunction

  localparam int DW = dw_of(DEFAULT_N);
  localparam int VW = vw_of(DEFAULT_N);
  localparam int RW = rw_of(DEFAULT_N);
  localparam int CW = cw_of(DEFAULT_N);

endpackage

// File: rtl/gf2_msb_index.sv
// Priority encoder: index of the highest set bit of vec, plus an all-zero flag.
module gf2_msb_index #(
  parameter int W  = 8,
  parameter int IW = (W > 1) ? $clog2(W) : 1
) (
  input  logic [W-1:0]  vec,
  output logic [IW-1:0] idx,
  output logic          zero
);

  always_comb begin
    // NOTE: every output gets a default before the loop so no latch is inferred.
    idx  = '0;
    zero = (vec == '0);
    for (int i = 0; i < W; i++) begin
      if (vec[i]) idx = IW'(i);
    end
  end

endmodule

// File: rtl/gf2_poly_divider.sv
// Bit-serial GF(2)[x] long divider: one dividend bit per clock, MSB first.
import gf2_pkg::*;

module gf2_poly_divider #(
  parameter int N = DEFAULT_N
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [2*N-2:0] dividend,
  input  logic [N:0]     divisor,
  output logic           ready,
  output logic           done,
  output logic           err,
  output logic [2*N-2:0] quotient,
  output logic [N-1:0]   remainder
);

  localparam int LDW = dw_of(N);
  localparam int LVW = vw_of(N);
  localparam int LRW = rw_of(N);
  localparam int LCW = cw_of(N);
  localparam int IW  = $clog2(LVW);

  state_t         state;
  logic [LDW-1:0] d_q;
  logic [LDW-1:0] q_q;
  // Divisor bit N is only needed by the degree encoder: (T ^ V)[N] is always 0.
  logic [LRW-1:0] v_q;
  logic [LRW-1:0] r_q;
  logic [LCW-1:0] k_q;
  logic [IW-1:0]  deg_q;
  logic           zf_q;

  logic [IW-1:0]  deg_in;
  logic           div_zero;
  logic [LVW-1:0] t;
  logic           hit;

  gf2_msb_index #(.W(LVW), .IW(IW)) u_msb (
    .vec  (divisor),
    .idx  (deg_in),
    .zero (div_zero)
  );

  always_comb begin
    t   = {r_q, d_q[LDW-1]};
    hit = t[deg_q];
  end

  // NOTE: the shift registers are plain flops, so clearing them on reset is cheap and keeps state deterministic.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      d_q       <= '0;
      q_q       <= '0;
      v_q       <= '0;
      r_q       <= '0;
      k_q       <= '0;
      deg_q     <= '0;
      zf_q      <= 1'b0;
      ready     <= 1'b1;
      done      <= 1'b0;
      err       <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
    end else begin
      // NOTE: non-blocking assignments here so every register sees pre-edge values.
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            d_q   <= dividend;
            v_q   <= divisor[LRW-1:0];
            deg_q <= deg_in;
            r_q   <= '0;
            q_q   <= '0;
            k_q   <= '0;
            zf_q  <= div_zero;
            err   <= 1'b0;
            ready <= 1'b0;
            state <= div_zero ? FIN : RUN;
          end
        end
        RUN: begin
          d_q <= d_q << 1;
          r_q <= t[LRW-1:0] ^ (hit ? v_q : '0);
          q_q <= {q_q[LDW-2:0], hit};
          k_q <= k_q + 1'b1;
          if (k_q == LCW'(LDW - 1)) state <= FIN;
        end
        FIN: begin
          done      <= 1'b1;
          ready     <= 1'b1;
          err       <= zf_q;
          quotient  <= zf_q ? '0 : q_q;
          remainder <= zf_q ? '0 : r_q;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gf2_poly_divider.sv
// Directed and randomised checks of gf2_poly_divider at N=8 against a software long-division model.
module tb_gf2_poly_divider;

  localparam int N  = 8;
  localparam int DW = 2 * N - 1;
  localparam int VW = N + 1;
  localparam int RW = N;
  localparam int LAT = 2 * N;

  logic          clk;
  logic          rst;
  logic          start;
  logic [DW-1:0] dividend;
  logic [VW-1:0] divisor;
  logic          ready;
  logic          done;
  logic          err;
  logic [DW-1:0] quotient;
  logic [RW-1:0] remainder;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  gf2_poly_divider #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .ready     (ready),
    .done      (done),
    .err       (err),
    .quotient  (quotient),
    .remainder (remainder)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int msb(input logic [31:0] x);
    int m = -1;
    for (int i = 0; i < 32; i++) if (x[i]) m = i;
    return m;
  endfunction

  function automatic logic [31:0] clmul(input logic [DW-1:0] a, input logic [VW-1:0] b);
    logic [31:0] acc = '0;
    for (int i = 0; i < DW; i++) if (a[i]) acc ^= 32'(b) << i;
    return acc;
  endfunction

  task automatic divmod(input logic [DW-1:0] d, input logic [VW-1:0] v,
                        output logic [DW-1:0] q, output logic [RW-1:0] r);
    logic [31:0] rem;
    int dg;
    rem = 32'(d);
    q   = '0;
    dg  = msb(32'(v));
    for (int i = DW - 1; i >= dg; i--) begin
      if (rem[i]) begin
        rem ^= 32'(v) << (i - dg);
        q[i-dg] = 1'b1;
      end
    end
    r = rem[RW-1:0];
  endtask

  // Waits for ready, issues one request, then counts edges until done (bounded).
  task automatic run_div(input logic [DW-1:0] d, input logic [VW-1:0] v, output int lat);
    int n = 0;
    while (!ready && n < 100) begin
      step();
      n++;
    end
    if (!ready) check("ready_timeout", 32'(ready), 32'd1);
    start    = 1'b1;
    dividend = d;
    divisor  = v;
    step();
    start    = 1'b0;
    dividend = DW'($urandom);
    divisor  = VW'($urandom);
    lat = 0;
    while (!done && lat < 100) begin
      step();
      lat++;
    end
    if (!done) check("done_timeout", 32'(done), 32'd1);
  endtask

  initial begin
    int lat;
    int dones;
    logic [DW-1:0] d, eq;
    logic [VW-1:0] v;
    logic [RW-1:0] er;

    rst      = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    step();
    step();
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_quot", 32'(quotient), 32'd0);
    check("rst_rem", 32'(remainder), 32'd0);
    rst = 1'b1;
    step();

    // AES field: 0x53 * 0xCA = 1
    run_div(15'h3F7E, 9'h11B, lat);
    check("aes_latency", 32'(lat), 32'(LAT));
    check("aes_quot", 32'(quotient), 32'h3D);
    check("aes_rem", 32'(remainder), 32'h01);
    check("aes_err", 32'(err), 32'd0);
    step();
    check("aes_done_pulse", 32'(done), 32'd0);
    check("aes_hold_quot", 32'(quotient), 32'h3D);

    run_div(15'h1234, 9'h000, lat);
    check("zero_latency", 32'(lat), 32'd1);
    check("zero_err", 32'(err), 32'd1);
    check("zero_quot", 32'(quotient), 32'd0);
    check("zero_rem", 32'(remainder), 32'd0);
    step();
    check("zero_ready", 32'(ready), 32'd1);
    check("zero_err_held", 32'(err), 32'd1);

    run_div(15'h5A5A, 9'h001, lat);
    check("deg0_quot", 32'(quotient), 32'h5A5A);
    check("deg0_rem", 32'(remainder), 32'd0);
    check("deg0_err", 32'(err), 32'd0);
    run_div(15'h00B7, 9'h100, lat);
    check("deg8_quot", 32'(quotient), 32'd0);
    check("deg8_rem", 32'(remainder), 32'hB7);

    // A second start during RUN must be ignored.
    start    = 1'b1;
    dividend = 15'h3F7E;
    divisor  = 9'h11B;
    step();
    start = 1'b0;
    check("run_ready_low", 32'(ready), 32'd0);
    for (int i = 0; i < 4; i++) step();
    start    = 1'b1;
    dividend = 15'h0001;
    divisor  = 9'h001;
    step();
    start = 1'b0;
    lat = 5;
    while (!done && lat < 100) begin
      step();
      lat++;
    end
    check("ign_latency", 32'(lat), 32'(LAT));
    check("ign_quot", 32'(quotient), 32'h3D);
    check("ign_rem", 32'(remainder), 32'h01);
    dones = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (done) dones++;
    end
    check("ign_no_second_done", 32'(dones), 32'd0);

    // Reset in the middle of a division.
    start    = 1'b1;
    dividend = 15'h3F7E;
    divisor  = 9'h11B;
    step();
    start = 1'b0;
    for (int i = 0; i < 7; i++) step();
    @(posedge clk);
    rst = 1'b0;
    #1;
    check("midrst_ready", 32'(ready), 32'd1);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_quot", 32'(quotient), 32'd0);
    check("midrst_rem", 32'(remainder), 32'd0);
    check("midrst_err", 32'(err), 32'd0);
    step();
    rst = 1'b1;
    step();
    run_div(15'h5A5A, 9'h11B, lat);
    divmod(15'h5A5A, 9'h11B, eq, er);
    check("fresh_latency", 32'(lat), 32'(LAT));
    check("fresh_quot", 32'(quotient), 32'(eq));
    check("fresh_rem", 32'(remainder), 32'(er));

    // Back-to-back random traffic.
    for (int i = 0; i < 1000; i++) begin
      d = DW'($urandom);
      v = VW'($urandom_range(1, (1 << VW) - 1));
      run_div(d, v, lat);
      divmod(d, v, eq, er);
      check("rnd_latency", 32'(lat), 32'(LAT));
      check("rnd_quot", 32'(quotient), 32'(eq));
      check("rnd_rem", 32'(remainder), 32'(er));
      check("rnd_identity", clmul(quotient, v) ^ 32'(remainder), 32'(d));
      check("rnd_rem_degree", 32'(msb(32'(remainder)) < msb(32'(v))), 32'd1);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
